// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared FSM state encoding and requester count for the shared
//               shift-add multiplier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int c_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_share_arb_if.sv
// ============================================================================
// Module      : mult_share_arb_if
// Description : Two-requester operand/response bus for the shared multiplier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mult_share_arb_if #(
    parameter int M = 5
);
    logic           req0_valid;
    logic           req1_valid;
    logic [M-1:0]   req0_a;
    logic [M-1:0]   req0_b;
    logic [M-1:0]   req1_a;
    logic [M-1:0]   req1_b;
    logic           req0_ready;
    logic           req1_ready;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*M-1:0] rsp_s;
    logic           rsp_ready;
    logic           busy;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_s, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_s, busy
    );
endinterface

`default_nettype wire

// File: rtl/mult_core.sv
// ============================================================================
// Module      : mult_core
// Description : Iterative shift-add datapath: accumulator, multiplier shift
//               register and step counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_core
    import mult_pkg::*;
#(
    parameter int M = 5
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           i_load,
    input  wire logic           i_step,
    input  wire logic [M-1:0]   i_mcand,
    input  wire logic [M-1:0]   i_mplr,
    output logic                o_last,
    output logic [2*M-1:0]      o_prod_next
);

    localparam int c_CW = $clog2(M + 1);

    logic [2*M-1:0] r_acc;
    logic [M-1:0]   r_mplr;
    logic [c_CW-1:0] r_count;
    logic [M:0]     w_sum;
    logic [2*M-1:0] w_acc_next;

    // The add carry lands in the MSB of the shifted accumulator, so no bit is lost.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*M-1:M]} + (r_mplr[0] ? {1'b0, i_mcand} : {(M+1){1'b0}});
        w_acc_next = {w_sum, r_acc[M-1:1]};
    end

    assign o_prod_next = w_acc_next;
    assign o_last      = (r_count == c_CW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_mplr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mplr  <= i_mplr;
            r_count <= c_CW'(M);
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_mplr  <= r_mplr >> 1;
            r_count <= r_count - c_CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_arb.sv
// ============================================================================
// Module      : mult_share_arb
// Description : Round-robin arbiter and control FSM sharing one shift-add
//               multiplier between two requesters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mult_share_arb
    import mult_pkg::*;
#(
    parameter int M = 5
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mult_share_arb_if.slave  bus
);

    state_t                 r_state;
    logic                   r_last_gnt;
    logic [M-1:0]           r_a;
    logic [M-1:0]           r_b;
    logic                   r_id;
    logic                   r_rsp_id;
    logic [2*M-1:0]         r_rsp_s;

    logic [c_NUM_REQ-1:0]   w_valid;
    logic                   w_any;
    logic                   w_gnt_id;
    logic [M-1:0]           w_gnt_a;
    logic [M-1:0]           w_gnt_b;
    logic                   w_last_step;
    logic [2*M-1:0]         w_prod_next;

    // With both valid, the requester that did not win last time gets the grant.
    always_comb begin
        w_valid  = {bus.req1_valid, bus.req0_valid};
        w_any    = |w_valid;
        w_gnt_id = (&w_valid) ? ~r_last_gnt : w_valid[1];
        w_gnt_a  = w_gnt_id ? bus.req1_a : bus.req0_a;
        w_gnt_b  = w_gnt_id ? bus.req1_b : bus.req0_b;
    end

    assign bus.req0_ready = reset_n && (r_state == ST_IDLE) && w_any && !w_gnt_id;
    assign bus.req1_ready = reset_n && (r_state == ST_IDLE) && w_any &&  w_gnt_id;
    assign bus.rsp_valid  = (r_state == ST_DONE);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_s      = r_rsp_s;
    assign bus.busy       = (r_state != ST_IDLE);

    mult_core #(
        .M (M)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (r_state == ST_LOAD),
        .i_step      (r_state == ST_RUN),
        .i_mcand     (r_a),
        .i_mplr      (r_b),
        .o_last      (w_last_step),
        .o_prod_next (w_prod_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_s    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a        <= w_gnt_a;
                        r_b        <= w_gnt_b;
                        r_id       <= w_gnt_id;
                        r_last_gnt <= w_gnt_id;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Capture the result of the final step as it is computed.
                    if (w_last_step) begin
                        r_rsp_s  <= w_prod_next;
                        r_rsp_id <= r_id;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
// ============================================================================
// Module      : tb_mult_share_arb
// Description : Randomized self-checking bench for mult_share_arb against a
//               behavioural round-robin/multiply model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_arb;

    localparam int M = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    mult_share_arb_if #(.M(M)) bus();

    mult_share_arb #(.M(M)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int exp_last = 1;   // model: requester granted most recently

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        bus.req0_valid = 1'($urandom);
        bus.req1_valid = 1'($urandom);
        bus.req0_a     = M'($urandom);
        bus.req0_b     = M'($urandom);
        bus.req1_a     = M'($urandom);
        bus.req1_b     = M'($urandom);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b0;
        #1;
        chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        tick();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_s", bus.rsp_s, 0);
        chk("rst_busy", bus.busy, 0);
        reset_n        = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_last       = 1;
    endtask

    task automatic issue(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input int hold);
        int gid;
        int exp_s;
        int lat;
        bus.req0_valid = v0;
        bus.req0_a     = M'(a0);
        bus.req0_b     = M'(b0);
        bus.req1_valid = v1;
        bus.req1_a     = M'(a1);
        bus.req1_b     = M'(b1);
        bus.rsp_ready  = 1'b0;
        #1;
        if (v0 && v1) gid = (exp_last == 0) ? 1 : 0;
        else          gid = v1 ? 1 : 0;
        exp_s = (gid == 1) ? a1 * b1 : a0 * b0;
        chk("grant_ready0", bus.req0_ready, gid == 0);
        chk("grant_ready1", bus.req1_ready, gid == 1);
        chk("idle_busy", bus.busy, 0);
        tick();
        exp_last = gid;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            scramble_inputs();
            #1;
            chk("run_ready_busy", {bus.req1_ready, bus.req0_ready, bus.busy}, 1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, M + 2);
        chk("rsp_s", bus.rsp_s, exp_s);
        chk("rsp_id", bus.rsp_id, gid);
        for (int i = 0; i < hold; i++) begin
            scramble_inputs();
            tick();
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_s", bus.rsp_s, exp_s);
            chk("hold_ready", {bus.req1_ready, bus.req0_ready}, 0);
            chk("hold_busy", bus.busy, 1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        bus.rsp_ready  = 1'b0;
        chk("post_valid", bus.rsp_valid, 0);
        chk("post_s_keep", bus.rsp_s, exp_s);
        chk("post_id_keep", bus.rsp_id, gid);
        chk("post_busy", bus.busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv0;
        bit rv1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b0;
        tick();
        do_reset();

        // Single requester, basic product.
        issue(1, 12, 11, 0, 0, 0, 0);

        // Contention straight after reset: req0, then req1, then req0 again.
        do_reset();
        issue(1, 29, 13, 1, 31, 31, 0);
        issue(1, 29, 13, 1, 31, 31, 0);
        issue(1, 29, 13, 1, 31, 31, 0);

        // Consumer stalls for four cycles in DONE.
        issue(1, 7, 9, 0, 0, 0, 4);

        // Reset during the third RUN cycle discards the operation.
        bus.req0_valid = 1'b1;
        bus.req0_a     = M'(9);
        bus.req0_b     = M'(9);
        bus.req1_valid = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n  = 1'b1;
        exp_last = 1;
        chk("midrst_valid", bus.rsp_valid, 0);
        chk("midrst_s", bus.rsp_s, 0);
        chk("midrst_busy", bus.busy, 0);
        for (int i = 0; i < M + 3; i++) begin
            tick();
            chk("midrst_quiet", bus.rsp_valid, 0);
        end
        issue(1, 3, 7, 0, 0, 0, 1);

        // Edge operands, inputs scrambled after acceptance.
        issue(1, 0, 31, 0, 0, 0, 0);
        issue(1, 31, 1, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 31, 31, 0);

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            issue(rv0, $urandom_range(0, 31), $urandom_range(0, 31),
                  rv1, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter M, default 5, giving the operand width in bits; the product is 2M bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, M bits each: the unsigned operands.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the request is accepted when valid && ready.
REQ-007 SHALL have port rsp_valid, output, 1 bit: the result is available.
REQ-008 SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-009 SHALL have port rsp_s, output, 2M bits: the unsigned product.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer takes the result when rsp_valid && rsp_ready.
REQ-011 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-013 SHALL, in IDLE with at least one reqN_valid high, assert exactly one reqN_ready combinationally (the granted requester); no ready is asserted in any other state.
REQ-014 SHALL grant round-robin: with one requester valid, that requester wins; with both valid, the requester not granted most recently wins.
REQ-015 SHALL, on acceptance, capture a, b and the requester id, record the grant, and move IDLE->LOAD.
REQ-016 SHALL ignore changes on reqN_a/reqN_b after acceptance; the operands are held internally.
REQ-017 SHALL, in LOAD, clear the accumulator, load the multiplier shift register, set the cycle counter to M, and move to RUN.
REQ-018 SHALL perform one shift-add step per RUN cycle: if the multiplier LSB is 1, add the multiplicand into the accumulator upper half; then shift {carry, accumulator} right by 1; decrement the counter.
REQ-019 SHALL move RUN->DONE after exactly M RUN cycles.
REQ-020 SHALL produce the exact unsigned product a*b in 2M bits with no truncation; the step carry is kept internal.
REQ-021 SHALL meet a fixed latency: acceptance in cycle T gives rsp_valid high from cycle T+M+2.
REQ-022 SHALL, in DONE, hold rsp_valid, rsp_id and rsp_s stable until rsp_ready is high; DONE->IDLE on handshake; minimum issue interval is M+3 cycles.
REQ-023 SHALL keep rsp_valid low outside DONE; rsp_s and rsp_id SHALL hold their last result when not valid.
REQ-024 SHALL not let a request that deasserts valid before acceptance affect the grant pointer.

Reset
REQ-025 SHALL, while reset_n is low at a clock edge, enter IDLE and drive rsp_valid=0, rsp_id=0, rsp_s=0, busy=0, both ready=0 and the counter=0, and set the grant pointer so req0 wins the first contention.
REQ-026 SHALL, on reset in any state including mid-RUN or DONE, discard the operation in flight with no response.

Structure
REQ-027 SHALL take the FSM state encoding and the requester-count constant (2) from a shared package mult_pkg.
REQ-028 SHALL place the shift-add datapath (accumulator, multiplier shift register, counter) in one sub-module mult_core, with the arbiter/FSM in mult_share_arb.

Verification (M=5)
REQ-029 SHALL test: req0 alone, a=12, b=11 -> rsp_valid at T+7, rsp_s=132, rsp_id=0.
REQ-030 SHALL test: req0 and req1 valid in the same cycle after reset (req0 29x13, req1 31x31) -> req0 first, 377 with id 0; then req1, 961 with id 1; then with both valid again, req0 wins.
REQ-031 SHALL test: rsp_ready low for 4 cycles in DONE -> rsp_valid and rsp_s stable, both ready low, busy=1.
REQ-032 SHALL test: reset_n low for 1 cycle during the 3rd RUN cycle -> next cycle IDLE, rsp_valid=0, rsp_s=0; a new request 3x7 returns 21.
REQ-033 SHALL test edge operands: 0x31 -> 0; 31x1 -> 31; 31x31 -> 961, with the operand inputs changed after acceptance having no effect.
